button_pulse_gen: RTL and testbench
===================================

BUTTON_PULSE_GEN -- requirements
Module: button_pulse_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000; cycles of stable level required to accept a press or release (legal minimum 2).
REQ-002 Parameter REPEAT_DELAY, default 25000000; cycles held in PRESSED before the first auto-repeat pulse (used only with AUTO_REPEAT_EN).
REQ-003 Parameter REPEAT_PERIOD, default 10000000; cycles between auto-repeat pulses (used only with AUTO_REPEAT_EN).
REQ-004 clk  input  1  single system clock; all flops clocked on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 btn_raw  input  1  raw, bouncing, asynchronous push-button level (1 = pressed).
REQ-007 pulse  output  1  registered one-cycle strobe per accepted press; feeds the downstream toggle FSM's pulse input.
REQ-008 btn_level  output  1  registered debounced button level.

Function
REQ-009 btn_raw SHALL pass through a two-flop synchronizer; the FSM SHALL see only the second flop (btn_s).
REQ-010 FSM states SHALL be IDLE, PRESS_CHK, PRESSED, REL_CHK.
REQ-011 IDLE: btn_s=1 -> PRESS_CHK with cnt cleared to 0; otherwise stay in IDLE.
REQ-012 PRESS_CHK: btn_s=0 -> IDLE (bounce rejected, no pulse); btn_s=1 with cnt=DEBOUNCE_CYCLES-1 -> PRESSED; otherwise cnt+1.
REQ-013 PRESSED: btn_s=0 -> REL_CHK with cnt cleared to 0.
REQ-014 REL_CHK: btn_s=1 -> PRESSED (bounce, no new pulse); btn_s=0 with cnt=DEBOUNCE_CYCLES-1 -> IDLE; otherwise cnt+1.
REQ-015 pulse SHALL be 1 for exactly the first cycle after the transition PRESS_CHK->PRESSED; it is 0 in all other cycles except as given in REQ-022.
REQ-016 Latency: if edge 0 is the first edge sampling btn_raw=1 and btn_raw stays 1, pulse SHALL be high between edges DEBOUNCE_CYCLES+2 and DEBOUNCE_CYCLES+3.
REQ-017 btn_level SHALL be 1 in PRESSED and REL_CHK and 0 in IDLE and PRESS_CHK; it rises in the same cycle pulse rises.
REQ-018 A release SHALL never generate a pulse.
REQ-019 cnt width SHALL be $clog2(DEBOUNCE_CYCLES); cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-020 A button held through reset deassertion SHALL be treated as a new press, producing one pulse after the REQ-016 latency.

Reset
REQ-021 rst_n=0 SHALL immediately force: state=IDLE, synchronizer flops=0, cnt=0, repeat counter=0, pulse=0, btn_level=0. A reset in any state, including mid-debounce, SHALL abandon the operation with no pulse.

Configuration
REQ-022 With AUTO_REPEAT_EN defined: while in PRESSED, a repeat counter SHALL issue an additional one-cycle pulse REPEAT_DELAY cycles after the initial pulse, then one every REPEAT_PERIOD cycles. The counter SHALL hold its value during REL_CHK and SHALL clear on entry to IDLE.
REQ-023 Without AUTO_REPEAT_EN: no repeat counter is generated, exactly one pulse is produced per accepted press, and REPEAT_DELAY and REPEAT_PERIOD are ignored.

Structure
REQ-024 Shared package btn_pkg SHALL hold the state enum type and the default constants for DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD.
REQ-025 The synchronizer SHALL be a separate sub-module, sync_2ff (1-bit, clk and rst_n), reusable by other input blocks.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-026 Clean press: btn_raw 0->1 first sampled at edge 0 and held -> pulse=1 only between edges 6 and 7; btn_level=1 from edge 6.
REQ-027 Bounce: btn_raw high 3 cycles, low 1, high 2, then low -> pulse and btn_level stay 0 throughout.
REQ-028 Release bounce: held press, then btn_raw low 2 cycles, high 1, low held -> no second pulse; btn_level falls 6 cycles after the final falling sample.
REQ-029 Reset mid-PRESS_CHK: rst_n=0 two cycles into the debounce count -> all outputs 0 immediately; with btn_raw still 1 after reset release, one pulse follows 6 edges later.
REQ-030 AUTO_REPEAT_EN, button held 30 cycles after the first pulse -> additional pulses 10, 15, 20, 25 and 30 cycles after the first pulse; without the macro, exactly one pulse.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button input blocks.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESS_CHK = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_REL_CHK   = 2'd3
  } btn_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DFLT = 500000;
  localparam int unsigned REPEAT_DELAY_DFLT    = 25000000;
  localparam int unsigned REPEAT_PERIOD_DFLT   = 10000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Latency: 2 cycles. Backpressure: none, free-running.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_pulse_gen.sv
// Debounced push-button to one-cycle press strobe (optional auto-repeat under AUTO_REPEAT_EN).
// Latency: pulse high DEBOUNCE_CYCLES+2 edges after the first high sample. Backpressure: none.
module button_pulse_gen
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DFLT,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse,
  output logic btn_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          btn_s;
  btn_state_e    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept;
  logic          pulse_nxt;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (btn_s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (btn_s) begin
          state_nxt = ST_PRESS_CHK;
          cnt_nxt   = '0;
        end
      end
      ST_PRESS_CHK: begin
        if (!btn_s) begin
          state_nxt = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_PRESSED;
          accept    = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_PRESSED: begin
        if (!btn_s) begin
          state_nxt = ST_REL_CHK;
          cnt_nxt   = '0;
        end
      end
      ST_REL_CHK: begin
        // A high sample here is release bounce: resume PRESSED without a new strobe.
        if (btn_s) begin
          state_nxt = ST_PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RPT_MAX + 1);

  logic [RW-1:0] rpt_cnt;
  logic [RW-1:0] rpt_tgt;
  logic          rpt_first;
  logic          rpt_fire;

  // First repeat waits REPEAT_DELAY PRESSED cycles, later ones REPEAT_PERIOD.
  assign rpt_tgt  = rpt_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
  assign rpt_fire = (state == ST_PRESSED) && (rpt_cnt == rpt_tgt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (state_nxt == ST_IDLE) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else if (state == ST_PRESSED) begin
      rpt_cnt <= rpt_cnt + RW'(1);
    end
  end

  assign pulse_nxt = accept | rpt_fire;
`else
  assign pulse_nxt = accept;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pulse     <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pulse     <= pulse_nxt;
      btn_level <= (state_nxt == ST_PRESSED) || (state_nxt == ST_REL_CHK);
    end
  end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Scoreboard bench for button_pulse_gen: run-length debounce model, directed cases plus random bursts.
module tb_button_pulse_gen;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_raw = 1'b0;
  logic pulse;
  logic btn_level;

  button_pulse_gen #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .pulse     (pulse),
    .btn_level (btn_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   tag;
    logic lvl;
  } exp_t;

  exp_t exp_q[$];
  int   pulse_q[$];
  int   obs_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int step_n = 0;
  int mon_fall_tag = -1;

  // Reference model: raw seen two samples late; level flips after D+1 consecutive opposite samples.
  bit m_s1, m_s2, m_lvl;
  int m_run, m_pcnt;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d (step %0d)", name, act, req, step_n);
    end
  endtask

  task automatic model_edge(input bit raw);
    bit seen, fire, pressed_pre;
    seen        = m_s2;
    fire        = 1'b0;
    pressed_pre = m_lvl && (m_run == 0);
    if (seen != m_lvl) m_run++;
    else m_run = 0;
    if (m_run == D + 1) begin
      m_lvl  = !m_lvl;
      m_run  = 0;
      m_pcnt = 0;
      if (m_lvl) fire = 1'b1;
    end
`ifdef AUTO_REPEAT_EN
    if (pressed_pre) begin
      m_pcnt++;
      if (m_pcnt == RD || (m_pcnt > RD && (m_pcnt - RD) % RP == 0)) fire = 1'b1;
    end
`endif
    if (fire) pulse_q.push_back(step_n);
    exp_q.push_back('{tag: step_n, lvl: m_lvl});
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic step(input bit raw, input bit rstn);
    @(negedge clk);
    btn_raw = raw;
    rst_n   = rstn;
    if (!rstn) begin
      #1;
      chk("reset_pulse_now", int'(pulse), 0);
      chk("reset_level_now", int'(btn_level), 0);
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_pcnt = 0;
      exp_q.push_back('{tag: step_n, lvl: 1'b0});
    end else begin
      model_edge(raw);
    end
    step_n++;
  endtask

  task automatic hold(input bit raw, input int n);
    repeat (n) step(raw, 1'b1);
  endtask

  // Monitor: one expectation per edge; pulse expectations popped when pulse is seen or due.
  always @(posedge clk) begin
    exp_t e;
    bit   exp_p;
    bit   lvl_prev;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("btn_level", int'(btn_level), int'(e.lvl));
      exp_p = (pulse_q.size() > 0) && (pulse_q[0] == e.tag);
      if (exp_p) void'(pulse_q.pop_front());
      if (pulse || exp_p) chk("pulse", int'(pulse), int'(exp_p));
      if (pulse) obs_q.push_back(e.tag);
      if (lvl_prev && !btn_level) mon_fall_tag = e.tag;
      lvl_prev = btn_level;
    end
  end

  initial begin
    int t0;
    int t1;
    repeat (3) step(1'b0, 1'b0);
    hold(1'b0, 4);

    // Clean press: pulse six edges after the first high sample.
    obs_q.delete();
    t0 = step_n;
    hold(1'b1, 20);
    chk("clean_pulse_seen", (obs_q.size() > 0) ? 1 : 0, 1);
    if (obs_q.size() > 0) chk("clean_pulse_edge", obs_q[0], t0 + 6);
    hold(1'b0, 12);

    // Press bounce: never accepted.
    obs_q.delete();
    hold(1'b1, 3); hold(1'b0, 1); hold(1'b1, 2); hold(1'b0, 10);
    chk("bounce_pulses", obs_q.size(), 0);

    // Release bounce: one pulse only, level falls six edges after final low sample.
    obs_q.delete();
    hold(1'b1, 12); hold(1'b0, 2); hold(1'b1, 1);
    t1 = step_n;
    hold(1'b0, 10);
    chk("rel_bounce_pulses", obs_q.size(), 1);
    chk("rel_fall_edge", mon_fall_tag, t1 + 6);

    // Reset two counts into the debounce, button still held through release.
    obs_q.delete();
    hold(1'b1, 5);
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    t1 = step_n;
    hold(1'b1, 12);
    chk("rst_mid_pulses", obs_q.size(), 1);
    if (obs_q.size() > 0) chk("rst_mid_edge", obs_q[0], t1 + 6);
    // Reset while pressed drops the level at once.
    step(1'b0, 1'b0);
    hold(1'b0, 6);

    // Long hold: auto-repeat spacing.
    obs_q.delete();
    t0 = step_n;
    hold(1'b1, 37);
    hold(1'b0, 12);
`ifdef AUTO_REPEAT_EN
    chk("repeat_count", obs_q.size(), 6);
    for (int i = 0; i < 6 && i < obs_q.size(); i++)
      chk("repeat_edge", obs_q[i], t0 + 6 + ((i == 0) ? 0 : RD + (i - 1) * RP));
`else
    chk("single_pulse_count", obs_q.size(), 1);
    if (obs_q.size() > 0) chk("single_pulse_edge", obs_q[0], t0 + 6);
`endif

    // Random bursts with occasional resets.
    for (int s = 0; s < 160; s++) begin
      int len;
      if ($urandom_range(0, 39) == 0) begin
        repeat ($urandom_range(1, 3)) step(1'($urandom_range(0, 1)), 1'b0);
      end else begin
        len = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 45) : $urandom_range(1, 8);
        hold(1'($urandom_range(0, 1)), len);
      end
    end

    hold(1'b0, 12);
    @(posedge clk);
    #3;
    chk("pending_pulses", pulse_q.size(), 0);
    chk("pending_levels", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
